// File: rtl/uart_stream_tx.sv
// Byte-stream to asynchronous serial transmitter (8N1, or 8E1 when
// UART_STREAM_TX_PARITY_EN is defined) with canPeek/peek/consume input.
module uart_stream_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_canPeek,
    input  logic [7:0]  in_peek,
    output logic        in_consume_en,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [7:0]       shift;
    logic             term;
`ifdef UART_STREAM_TX_PARITY_EN
    logic             par;
`endif

    assign term          = (cnt == TERM);
    assign busy          = (state != IDLE);
    // Gated by reset so no byte is dequeued while the transmitter is held.
    assign in_consume_en = reset && (state == IDLE) && in_canPeek;

    // uart_tx is loaded with the level of the bit about to be driven, so the
    // line always comes straight from a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            uart_tx     <= 1'b1;
            frames_sent <= '0;
`ifdef UART_STREAM_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            if (state != IDLE)
                cnt <= term ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (in_canPeek) begin
                        shift   <= in_peek;
                        cnt     <= '0;
                        idx     <= '0;
                        uart_tx <= 1'b0;
                        state   <= START;
`ifdef UART_STREAM_TX_PARITY_EN
                        par     <= ^in_peek;
`endif
                    end
                end
                START: begin
                    if (term) begin
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (term) begin
                        shift <= {1'b0, shift[7:1]};
                        if (idx == 4'd7) begin
`ifdef UART_STREAM_TX_PARITY_EN
                            uart_tx <= par;
                            state   <= PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            idx     <= idx + 4'd1;
                            uart_tx <= shift[1];
                        end
                    end
                end
`ifdef UART_STREAM_TX_PARITY_EN
                PARITY: begin
                    if (term) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (term) begin
                        uart_tx     <= 1'b1;
                        frames_sent <= frames_sent + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
